// File: rtl/eq_sched.sv
// Equalizer scheduler: gathers channel-estimate completion, queues buffered data symbols, and walks the shared
// equalizer over 12 subcarriers per symbol via req/ack; request is issued one cycle after selection and held until acked.
module eq_sched (
   input  logic        i_clk_est,
   input  logic        i_rst_n,
   input  logic        i_slot_start,
   input  logic        i_sym_valid,
   input  logic [2:0]  i_symbol_num,
   input  logic [11:0] i_est_done,
   input  logic        i_eq_ack,
   output logic        o_eq_req,
   output logic [3:0]  o_sc_indx,
   output logic [2:0]  o_sym_indx,
   output logic        o_sym_done,
   output logic        o_slot_done,
   output logic        o_sym_err
);
   localparam int N_SC      = 12;
   localparam int N_SYM     = 7;
   localparam int PILOT_SYM = 4;

   localparam logic [3:0] SC_LAST  = 4'(N_SC - 1);
   localparam logic [2:0] SRV_LAST = 3'(N_SYM - 1);
   localparam logic [2:0] PILOT    = 3'(PILOT_SYM);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ISSUE,
      SYM_DONE,
      SLOT_DONE
   } state_t;

   state_t           state;
   logic [N_SC-1:0]  est_mask;
   logic [N_SYM-1:0] pending;
   logic [2:0]       cur_sym;
   logic [3:0]       sc_cnt;
   logic [2:0]       served;
   logic             err_q;

   logic             active;
   logic             est_ready;
   logic             sel_vld;
   logic             sel_go;
   logic             cur_busy;
   logic             sym_err;
   logic             sym_take;
   logic [2:0]       sel_sym;
   logic [N_SYM-1:0] sel_bit;
   logic [N_SYM-1:0] sym_bit;
   logic [N_SYM-1:0] pend_base;
   logic [N_SYM-1:0] pend_nxt;

   assign active    = (state != IDLE);
   assign est_ready = &est_mask;
   assign sel_go    = !i_slot_start && (state == COLLECT) && (served != SRV_LAST)
                      && est_ready && sel_vld;

   // Lowest pending symbol wins; the loop runs high-to-low so the last hit is the lowest.
   always_comb begin
      sel_vld = |pending;
      sel_sym = '0;
      sel_bit = '0;
      for (int k = N_SYM - 1; k >= 0; k--) begin
         if (pending[k]) begin
            sel_sym    = 3'(k + 1);
            sel_bit    = '0;
            sel_bit[k] = 1'b1;
         end
      end
   end

   // An abort in the same cycle empties pending first, so the new symbol lands in the fresh slot.
   always_comb begin
      for (int k = 0; k < N_SYM; k++) begin
         sym_bit[k] = (i_symbol_num == 3'(k + 1));
      end
      pend_base = i_slot_start ? '0 : pending;
      cur_busy  = !i_slot_start && ((state == ISSUE) || (state == SYM_DONE))
                  && (i_symbol_num == cur_sym);
      sym_err   = 1'b0;
      sym_take  = 1'b0;
      if (active && i_sym_valid && (i_symbol_num != PILOT)) begin
         if ((sym_bit == '0) || ((pend_base & sym_bit) != '0) || cur_busy) begin
            sym_err = 1'b1;
         end else begin
            sym_take = 1'b1;
         end
      end
      pend_nxt = pend_base;
      if (sel_go) begin
         pend_nxt = pend_nxt & ~sel_bit;
      end
      if (sym_take) begin
         pend_nxt = pend_nxt | sym_bit;
      end
   end

   always_ff @(posedge i_clk_est or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         est_mask <= '0;
         pending  <= '0;
         cur_sym  <= '0;
         sc_cnt   <= '0;
         served   <= '0;
         err_q    <= 1'b0;
      end else begin
         pending <= pend_nxt;
         err_q   <= sym_err;

         if (i_slot_start) begin
            est_mask <= active ? i_est_done : '0;
         end else if (active) begin
            est_mask <= est_mask | i_est_done;
         end

         if (i_slot_start) begin
            state  <= COLLECT;
            served <= '0;
            sc_cnt <= '0;
         end else begin
            case (state)
               IDLE: ;
               COLLECT: begin
                  if (served == SRV_LAST) begin
                     state <= SLOT_DONE;
                  end else if (sel_go) begin
                     cur_sym <= sel_sym;
                     sc_cnt  <= '0;
                     state   <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (i_eq_ack) begin
                     if (sc_cnt == SC_LAST) begin
                        state <= SYM_DONE;
                     end else begin
                        sc_cnt <= sc_cnt + 4'd1;
                     end
                  end
               end
               SYM_DONE: begin
                  if (served != SRV_LAST) begin
                     served <= served + 3'd1;
                  end
                  state <= COLLECT;
               end
               SLOT_DONE: state <= IDLE;
               default:   state <= IDLE;
            endcase
         end
      end
   end

   assign o_eq_req    = (state == ISSUE);
   assign o_sc_indx   = sc_cnt;
   assign o_sym_indx  = cur_sym;
   assign o_sym_done  = (state == SYM_DONE);
   assign o_slot_done = (state == SLOT_DONE);
   assign o_sym_err   = err_q;

endmodule

// File: tb/tb_eq_sched.sv
// Directed bench for eq_sched: slot sequencing, pilot skip, random ack, error pulses, abort and async reset.
module tb_eq_sched;
   logic        i_clk_est    = 1'b0;
   logic        i_rst_n      = 1'b1;
   logic        i_slot_start = 1'b0;
   logic        i_sym_valid  = 1'b0;
   logic [2:0]  i_symbol_num = '0;
   logic [11:0] i_est_done   = '0;
   logic        i_eq_ack     = 1'b0;
   logic        o_eq_req;
   logic [3:0]  o_sc_indx;
   logic [2:0]  o_sym_indx;
   logic        o_sym_done;
   logic        o_slot_done;
   logic        o_sym_err;

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int err_seen  = 0;
   int done_seen = 0;
   int done_cyc  = 0;

   always #5 i_clk_est = ~i_clk_est;

   eq_sched dut (
      .i_clk_est   (i_clk_est),
      .i_rst_n     (i_rst_n),
      .i_slot_start(i_slot_start),
      .i_sym_valid (i_sym_valid),
      .i_symbol_num(i_symbol_num),
      .i_est_done  (i_est_done),
      .i_eq_ack    (i_eq_ack),
      .o_eq_req    (o_eq_req),
      .o_sc_indx   (o_sc_indx),
      .o_sym_indx  (o_sym_indx),
      .o_sym_done  (o_sym_done),
      .o_slot_done (o_slot_done),
      .o_sym_err   (o_sym_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge i_clk_est);
      #1;
      cyc++;
      err_seen  += int'(o_sym_err);
      done_seen += int'(o_sym_done);
   endtask

   task automatic pulse_sym(input logic [2:0] n);
      i_sym_valid  = 1'b1;
      i_symbol_num = n;
      tick();
      i_sym_valid  = 1'b0;
      i_symbol_num = '0;
   endtask

   task automatic feed_est();
      for (int b = 0; b < 12; b++) begin
         i_est_done = 12'b1 << b;
         tick();
      end
      i_est_done = '0;
   endtask

   // Entered at the first ISSUE cycle (sc 0) with ack held high; leaves at the following COLLECT cycle.
   task automatic serve(input logic [2:0] s);
      for (int i = 0; i < 12; i++) begin
         chk("serve_req", 32'(o_eq_req), 1);
         chk("serve_sc", 32'(o_sc_indx), i);
         chk("serve_sym", 32'(o_sym_indx), 32'(s));
         tick();
      end
      chk("serve_done", 32'(o_sym_done), 1);
      chk("serve_done_sym", 32'(o_sym_indx), 32'(s));
      done_cyc = cyc;
      tick();
      chk("serve_done_clr", 32'(o_sym_done), 0);
      chk("serve_req_clr", 32'(o_eq_req), 0);
   endtask

   initial begin
      int c1;
      int exp_sym;
      int exp_sc;
      int xfers;
      int nd;
      logic req_prev;

      // Reset state
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(o_eq_req), 0);
      chk("rst_sc", 32'(o_sc_indx), 0);
      chk("rst_sym", 32'(o_sym_indx), 0);
      chk("rst_symdone", 32'(o_sym_done), 0);
      chk("rst_slotdone", 32'(o_slot_done), 0);
      chk("rst_err", 32'(o_sym_err), 0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();

      // Slot with symbols 1,2,3, ack tied high
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      pulse_sym(3'd1);
      pulse_sym(3'd2);
      pulse_sym(3'd3);
      i_eq_ack = 1'b1;
      feed_est();
      chk("t1_no_req_yet", 32'(o_eq_req), 0);
      tick();
      serve(3'd1);
      c1 = done_cyc;
      tick();
      serve(3'd2);
      chk("t1_spacing12", done_cyc - c1, 14);
      c1 = done_cyc;
      tick();
      serve(3'd3);
      chk("t1_spacing23", done_cyc - c1, 14);

      // Symbols 5,4(pilot),6,7 then slot completion
      i_eq_ack = 1'b0;
      err_seen = 0;
      pulse_sym(3'd5);
      pulse_sym(3'd4);
      pulse_sym(3'd6);
      pulse_sym(3'd7);
      chk("t2_no_err", err_seen, 0);
      chk("t2_req_held", 32'(o_eq_req), 1);
      chk("t2_first_sym", 32'(o_sym_indx), 5);
      chk("t2_sc_held", 32'(o_sc_indx), 0);
      i_eq_ack = 1'b1;
      serve(3'd5);
      tick();
      serve(3'd6);
      tick();
      serve(3'd7);
      chk("t2_slot_not_yet", 32'(o_slot_done), 0);
      tick();
      chk("t2_slot_done", 32'(o_slot_done), 1);
      tick();
      chk("t2_slot_done_clr", 32'(o_slot_done), 0);
      pulse_sym(3'd3);
      chk("t2_idle_no_err", 32'(o_sym_err), 0);
      tick();
      tick();
      chk("t2_idle_no_req", 32'(o_eq_req), 0);

      // Random ack, ~30% duty
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      pulse_sym(3'd1);
      pulse_sym(3'd2);
      i_eq_ack = 1'b0;
      feed_est();
      exp_sym = 1;
      exp_sc  = 0;
      xfers   = 0;
      nd      = 0;
      for (int c = 0; c < 800 && nd < 2; c++) begin
         if (o_eq_req) begin
            chk("rand_sc", 32'(o_sc_indx), exp_sc);
            chk("rand_sym", 32'(o_sym_indx), exp_sym);
         end
         if (o_sym_done) begin
            chk("rand_acks", xfers, 12);
            chk("rand_done_sym", 32'(o_sym_indx), exp_sym);
            nd++;
            exp_sym++;
            exp_sc = 0;
            xfers  = 0;
         end
         i_eq_ack = ($urandom_range(0, 9) < 3);
         req_prev = o_eq_req;
         tick();
         if (req_prev && i_eq_ack) begin
            xfers++;
            exp_sc++;
         end
      end
      chk("rand_syms_done", nd, 2);

      // Duplicate, illegal and in-service symbol notifications
      i_eq_ack = 1'b0;
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      err_seen = 0;
      pulse_sym(3'd7);
      chk("t4_first7_ok", 32'(o_sym_err), 0);
      feed_est();
      tick();
      chk("t4_issue7", 32'(o_sym_indx), 7);
      pulse_sym(3'd7);
      chk("t4_own_issue_err", 32'(o_sym_err), 1);
      pulse_sym(3'd2);
      chk("t4_sym2_ok", 32'(o_sym_err), 0);
      pulse_sym(3'd2);
      chk("t4_dup_err", 32'(o_sym_err), 1);
      pulse_sym(3'd0);
      chk("t4_zero_err", 32'(o_sym_err), 1);
      tick();
      chk("t4_err_clr", 32'(o_sym_err), 0);
      chk("t4_still_sc0", 32'(o_sc_indx), 0);
      i_eq_ack = 1'b1;
      serve(3'd7);
      tick();
      serve(3'd2);
      tick();
      tick();
      chk("t4_served_once", 32'(o_eq_req), 0);
      chk("t4_err_total", err_seen, 3);

      // Abort mid-ISSUE at sc 5 of symbol 2
      i_eq_ack = 1'b0;
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      pulse_sym(3'd2);
      feed_est();
      tick();
      i_eq_ack = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t5_at_sc5", 32'(o_sc_indx), 5);
      i_eq_ack = 1'b0;
      done_seen = 0;
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      chk("t5_req_drop", 32'(o_eq_req), 0);
      pulse_sym(3'd3);
      for (int i = 0; i < 4; i++) tick();
      chk("t5_needs_est", 32'(o_eq_req), 0);
      chk("t5_no_symdone", done_seen, 0);
      feed_est();
      tick();
      chk("t5_new_req", 32'(o_eq_req), 1);
      chk("t5_new_sym", 32'(o_sym_indx), 3);

      // Asynchronous reset mid-ISSUE
      i_eq_ack = 1'b1;
      tick();
      tick();
      i_rst_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(o_eq_req), 0);
      chk("t6_rst_sc", 32'(o_sc_indx), 0);
      chk("t6_rst_sym", 32'(o_sym_indx), 0);
      chk("t6_rst_symdone", 32'(o_sym_done), 0);
      chk("t6_rst_slotdone", 32'(o_slot_done), 0);
      chk("t6_rst_err", 32'(o_sym_err), 0);
      #2 i_rst_n = 1'b1;
      tick();
      pulse_sym(3'd1);
      chk("t6_idle_sym_no_err", 32'(o_sym_err), 0);
      feed_est();
      chk("t6_idle_no_req", 32'(o_eq_req), 0);
      i_slot_start = 1'b1;
      tick();
      i_slot_start = 1'b0;
      pulse_sym(3'd3);
      tick();
      tick();
      chk("t6_est_cleared", 32'(o_eq_req), 0);
      i_slot_start = 1'b1;
      i_sym_valid  = 1'b1;
      i_symbol_num = 3'd6;
      tick();
      i_slot_start = 1'b0;
      i_sym_valid  = 1'b0;
      i_symbol_num = '0;
      chk("t6_restart_no_err", 32'(o_sym_err), 0);
      feed_est();
      tick();
      chk("t6_restart_req", 32'(o_eq_req), 1);
      chk("t6_restart_sym", 32'(o_sym_indx), 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/eq_sched.md
# eq_sched

Equalizer scheduler for the NB-IoT uplink receiver. It collects the per-subcarrier channel-estimate completion pulses produced during the pilot symbol. It records which data symbols have been fully captured by the serial-to-parallel buffer. It then sequences the shared complex equalizer over 12 subcarriers of each pending data symbol, using a req/ack handshake, in ascending symbol order, one slot at a time.

## Interface
- N_SC, 12, subcarriers per symbol
- N_SYM, 7, symbols per slot, numbered 1..N_SYM
- PILOT_SYM, 4, symbol number carrying DMRS; never equalized
- i_clk_est  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_slot_start  in  1  one-cycle pulse: begin or restart a slot
- i_sym_valid  in  1  one-cycle pulse: symbol i_symbol_num fully buffered
- i_symbol_num  in  3  symbol number qualified by i_sym_valid
- i_est_done  in  12  per-subcarrier estimate-complete pulses, bit k = subcarrier k
- i_eq_ack  in  1  equalizer accepted current request
- o_eq_req  out  1  equalization request
- o_sc_indx  out  4  subcarrier index of request, 0..N_SC-1
- o_sym_indx  out  3  symbol number being served
- o_sym_done  out  1  one-cycle pulse: all subcarriers of o_sym_indx equalized
- o_slot_done  out  1  one-cycle pulse: all N_SYM-1 data symbols equalized
- o_sym_err  out  1  one-cycle pulse: illegal or duplicate symbol notification

## Operation
- Registers:
  - est_mask[11:0]
  - pending[N_SYM-1:0], bit k-1 = symbol k
  - cur_sym[2:0]
  - sc_cnt[3:0]
  - served[2:0]
  - err_q
  - state
- est_ready = (est_mask == all ones).
- est_mask |= i_est_done every cycle outside IDLE.
- States and transitions:
  - IDLE: wait for i_slot_start, then go to COLLECT. i_sym_valid and i_est_done are ignored, with no error.
  - COLLECT:
    - If served == N_SYM-1, go to SLOT_DONE.
    - Else if est_ready and pending != 0: cur_sym <= lowest set pending index, clear that bit, sc_cnt <= 0, go to ISSUE.
    - Else stay in COLLECT.
  - ISSUE: o_eq_req=1, o_sc_indx=sc_cnt, o_sym_indx=cur_sym.
    - On i_eq_ack with sc_cnt == N_SC-1, go to SYM_DONE.
    - On i_eq_ack otherwise, sc_cnt++ and stay in ISSUE (back-to-back requests allowed).
    - Without ack, hold all request outputs stable.
  - SYM_DONE: o_sym_done=1 with o_sym_indx=cur_sym; served++; go to COLLECT.
  - SLOT_DONE: o_slot_done=1; go to IDLE.
- Symbol capture, outside IDLE, on i_sym_valid:
  - i_symbol_num == PILOT_SYM: ignored, no error.
  - i_symbol_num == 0 or > N_SYM: err_q set, pending unchanged.
  - Bit already pending, or equal to cur_sym while in ISSUE/SYM_DONE: err_q set (overrun), pending unchanged.
  - Else: set the pending bit.
- i_slot_start outside IDLE aborts the slot:
  - Next state is COLLECT.
  - est_mask, pending, served, sc_cnt cleared.
  - o_eq_req deasserts next cycle; no o_sym_done is issued for the aborted symbol.
- Simultaneous events:
  - i_slot_start with i_sym_valid: clear first, then capture the symbol into the fresh pending.
  - i_slot_start with i_est_done: the pulse bits are kept in the fresh est_mask.
  - i_sym_valid in the same cycle COLLECT selects: the selection uses the registered pending; the new bit is visible next cycle.
- Arithmetic:
  - sc_cnt and served are unsigned and never wrap. sc_cnt stops at N_SC-1; served stops at N_SYM-1.
  - Lowest-set-bit priority encoder over pending.
- Reset values:
  - state IDLE; all registers 0.
  - o_eq_req=0, o_sc_indx=0, o_sym_indx=0, o_sym_done=0, o_slot_done=0, o_sym_err=0.

## Timing
- All outputs are Moore-decoded from registered state/counters (o_sym_err = err_q); no combinational input-to-output path.
- Estimate readiness: the cycle after the last missing i_est_done bit is sampled, est_ready=1.
- Issue latency: COLLECT sees est_ready and pending at cycle N; o_eq_req=1 at N+1.
- Handshake: a transfer occurs on a rising edge with o_eq_req=1 and i_eq_ack=1. o_sc_indx updates in the following cycle.
- Per symbol with i_eq_ack tied high: 1 COLLECT + 12 ISSUE + 1 SYM_DONE = 14 cycles. A full slot then takes 6×14 + 1 COLLECT + 1 SLOT_DONE cycles after est_ready.
- o_sym_err is asserted the cycle after the offending i_sym_valid, for 1 cycle.

## Test plan
- Slot start, then symbols 1,2,3 valid, then est_done bits 0..11 one per cycle, i_eq_ack tied 1 -> requests for sym 1 sc 0..11 start 2 cycles after the bit-11 pulse; o_sym_done for sym 1, then 2, then 3, 14 cycles apart.
- Continue with symbols 5,6,7, with 4 (pilot) also pulsed -> sym 4 never served, no o_sym_err; o_slot_done pulses once after sym 7's o_sym_done; state returns to IDLE.
- i_eq_ack driven randomly (~30% high) -> o_sc_indx/o_sym_indx stable while unacked; exactly 12 acks per symbol; subcarrier indices strictly 0..11 in order.
- Symbol 2 pulsed twice, then symbol 0, then symbol 7 during its own ISSUE -> o_sym_err pulses 3 times; each symbol is served once.
- i_slot_start mid-ISSUE at sc 5 of sym 2 -> o_eq_req low next cycle, no o_sym_done; a new slot requires est_done again before any request.
- i_rst_n asserted mid-ISSUE -> all outputs 0 immediately; IDLE; i_sym_valid ignored until i_slot_start.
